uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter for the mini machine's serial output (`TxD1` class of pins). Each CPU write pushes one word into an internal FIFO. A framing state machine drains the FIFO and serialises each word as start, data (LSB first), optional parity and stop bits. It replaces the single-register, fixed-format transmitter: width, depth, parity, stop-bit count and baud divisor are configurable, back-to-back frames have no idle gap, and overflow is flagged.

## Interface
- `CLK_DIV`, 16, clock cycles per serial bit; legal values are ≥2.
- `DATA_W`, 8, data bits per frame; legal values are 5–9.
- `DEPTH`, 4, FIFO entries; must be a power of 2, ≥2.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1, number of stop bits: 1 or 2.

Ports:
- `clk` in 1: the only clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `we` in 1: write strobe, sampled on `clk`.
- `wdata` in `DATA_W`: word to enqueue.
- `clr_ovf` in 1: clears `ovf`.
- `full` out 1: FIFO holds `DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries.
- `count` out `$clog2(DEPTH)+1`: current FIFO occupancy.
- `busy` out 1: a frame is in progress (FSM not in IDLE).
- `ovf` out 1: sticky flag, set when a write was dropped.
- `TxD` out 1: serial line, idle high.

## Operation
- **FIFO**
  - Circular buffer with read pointer, write pointer and occupancy count.
  - A write with `we=1` and `full=0` stores `wdata` and increments `count`.
  - A write with `we=1` and `full=1` is dropped and sets `ovf`.
  - Write and pop in the same cycle leave `count` unchanged.
  - When full, a write coinciding with a pop is accepted.
  - Pointers wrap modulo `DEPTH`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `TxD`=1. If `empty=0`, pop the head word into the shift register and go to START.
  - START: `TxD`=0 for one bit time, then go to DATA.
  - DATA: shift out `DATA_W` bits, LSB first, one bit time each. Then go to PARITY if `PARITY`≠0, otherwise STOP.
  - PARITY: for even parity, send the XOR of the data bits. For odd parity, send its inverse. One bit time, then STOP.
  - STOP: `TxD`=1 for `STOP_BITS` bit times. At the end of the last stop bit:
    - if `empty=0`, pop and go directly to START;
    - otherwise go to IDLE.
- **Bit timer**
  - Counts 0..`CLK_DIV`-1 and advances the FSM bit on terminal count.
  - Resets to 0 on every state entry from IDLE.
- **`ovf`**
  - Cleared by `clr_ovf=1`.
  - If a dropped write and `clr_ovf` occur in the same cycle, set wins.
- **Popped words** are held in the shift register, so FIFO writes never disturb the frame in progress.

## Timing
- **Reset values:** `TxD`=1, `busy`=0, `full`=0, `empty`=1, `count`=0, `ovf`=0. Both pointers are 0, the FSM is in IDLE and the bit timer is 0. FIFO RAM contents are don't-care.
- **Reset mid-frame:** the frame is aborted, `TxD` goes high asynchronously and the FIFO is flushed.
- **Write latency:** a write accepted at edge N is visible on `count`/`empty` after edge N.
- **Start latency:** with the FSM in IDLE, the FSM pops at edge N+1. `busy`=1 and `TxD`=0 after edge N+1.
- **Bit duration:** every bit is held exactly `CLK_DIV` cycles.
- **Frame length:** `CLK_DIV`×(1+`DATA_W`+(`PARITY`≠0)+`STOP_BITS`) cycles.
- **Back-to-back frames:** the next start bit begins the cycle immediately after the final stop bit ends, with zero idle cycles. `busy` stays 1 throughout.
- **End of last frame:** `busy` falls the cycle after the final stop bit ends.
- **Output quality:** `TxD` is driven from a flop, so it is glitch-free.

## Test plan
- **Single frame, 0x55.** Set `CLK_DIV`=4, `DATA_W`=8, `PARITY`=1, `STOP_BITS`=1, then write 0x55.
  - Required `TxD` sequence: 0,1,0,1,0,1,0,1,0,0(parity),1, each bit 4 cycles wide.
  - Frame is 44 cycles; `busy` falls 44 cycles after it rose.
- **Parity modes, 0x07.**
  - `PARITY`=1 (even): parity bit = 1.
  - `PARITY`=2 (odd): parity bit = 0.
  - `PARITY`=0: no parity bit; the frame is 40 cycles.
- **Two stop bits.** With `STOP_BITS`=2, the frame is 48 cycles and `TxD` is high for the final 8 cycles.
- **Overflow and back-to-back frames.** Set `DEPTH`=4. Write 0xA1, wait until `busy`=1, then write 0xB1..0xB5 on consecutive cycles.
  - 0xB1..0xB4 are accepted; 0xB5 is dropped.
  - `full`=1 and `ovf`=1.
  - Five frames (0xA1, 0xB1..0xB4) appear with no idle gap.
  - `ovf` stays 1 until `clr_ovf` is pulsed.
- **Reset mid-frame.** Drop `reset` low during a DATA bit with `count`=2.
  - `TxD`=1 immediately, with no wait for a clock edge.
  - After release, `count`=0, `empty`=1 and `busy`=0, and no further frames are sent.
- **Simultaneous events.** With `full`=1, assert `we` in the exact cycle the FSM pops: the write is accepted and `count` stays 4. Assert `clr_ovf` together with a dropped write: `ovf` remains 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a DEPTH-entry FIFO feeding a start/data/parity/stop framer.
// Start bit is one cycle after a write to an idle block; writes to a full FIFO are dropped and raise ovf.
module uart_tx_fifo #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   ovf,
  output logic                   TxD
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [DATA_W-1:0] head;
  logic              pop;
  logic              wr_ok;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              tc;
  logic              stop_last;
  logic              load;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken.
  assign wr_ok = we && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop)      count <= count + 1'b1;
      else if (!wr_ok && pop) count <= count - 1'b1;
      if (we && !wr_ok)  ovf <= 1'b1;
      else if (clr_ovf)  ovf <= 1'b0;
    end
  end

  assign tc        = (timer_q == TW'(CLK_DIV - 1));
  assign stop_last = (STOP_BITS == 2) ? stop_q : 1'b1;

  // txd_d is the line level for the next cycle, so TxD comes straight off a flop.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    stop_d   = stop_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    load     = 1'b0;

    if (state_q != S_IDLE) timer_d = tc ? '0 : timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        txd_d   = 1'b1;
        if (!empty) load = 1'b1;
      end
      S_START: begin
        if (tc) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
          txd_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (tc) begin
          if (bitcnt_q == BW'(DATA_W - 1)) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              txd_d   = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            shreg_d  = shreg_q >> 1;
            txd_d    = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tc) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (tc) begin
          if (stop_last) begin
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      state_d = S_START;
      timer_d = '0;
      shreg_d = head;
      par_d   = (^head) ^ (PARITY == 2);
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      stop_q   <= stop_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign TxD  = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (even, odd, no parity, two stop bits) at CLK_DIV=4, DATA_W=8, DEPTH=4.
// Written words go into a scoreboard queue; each received frame is compared cycle by cycle against a framing model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] we;
  logic [3:0] clr_ovf;
  logic [7:0] wdata [4];
  wire  [3:0] full, empty, busy, ovf, txd;
  wire  [2:0] count [4];

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int P = (g == 1) ? 2 : ((g == 2) ? 0 : 1);
    localparam int S = (g == 3) ? 2 : 1;
    uart_tx_fifo #(
      .CLK_DIV(4), .DATA_W(8), .DEPTH(4), .PARITY(P), .STOP_BITS(S)
    ) u_dut (
      .clk(clk), .reset(rst_n), .we(we[g]), .wdata(wdata[g]), .clr_ovf(clr_ovf[g]),
      .full(full[g]), .empty(empty[g]), .count(count[g]), .busy(busy[g]),
      .ovf(ovf[g]), .TxD(txd[g])
    );
  end

  function automatic int par_of(input int k);
    return (k == 1) ? 2 : ((k == 2) ? 0 : 1);
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int nbits_of(input int k);
    return 9 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
  endfunction

  // Expected per-cycle line level of one frame, 4 cycles per bit, cycle 0 in bit 0.
  function automatic logic [63:0] exp_wave(input logic [7:0] d, input int k);
    logic [15:0] b;
    logic [63:0] w;
    int n;
    b = '0;
    w = '0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    n = 9;
    if (par_of(k) == 1) begin b[n] = ^d;  n++; end
    if (par_of(k) == 2) begin b[n] = ~^d; n++; end
    for (int s = 0; s < stop_of(k); s++) begin b[n] = 1'b1; n++; end
    for (int c = 0; c < n * 4; c++) w[c] = b[c/4];
    return w;
  endfunction

  task automatic write_word(input int k, input logic [7:0] d);
    @(negedge clk);
    we[k] = 1'b1;
    wdata[k] = d;
    @(negedge clk);
    we[k] = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples one full frame at negedges.
  task automatic rx_frame(input int k, output logic [63:0] wave, output int waited, output int busy_cyc);
    int n;
    n = nbits_of(k) * 4;
    wave = '0;
    waited = 0;
    busy_cyc = 0;
    @(negedge clk);
    while (txd[k] !== 1'b0 && waited < 400) begin
      waited++;
      @(negedge clk);
    end
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      wave[c] = txd[k];
      if (busy[k] === 1'b1) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    we = '0;
    clr_ovf = '0;
    for (int k = 0; k < 4; k++) wdata[k] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({txd[k], busy[k], full[k], empty[k], ovf[k]} !== 5'b10010) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got txd,busy,full,empty,ovf=%b required 10010", k,
                 {txd[k], busy[k], full[k], empty[k], ovf[k]});
      end
      checks++;
      if (count[k] !== 3'd0) begin
        errors++;
        $display("FAIL reset_count[%0d]: got %0d required 0", k, count[k]);
      end
    end
  endtask

  task automatic test_single_frame;
    logic [63:0] wave, exp;
    logic [10:0] bits;
    int waited, bc;
    sb.push_back(8'h55);
    write_word(0, 8'h55);
    checks++;
    if (count[0] !== 3'd1 || empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_latency: got count=%0d empty=%b required 1/0", count[0], empty[0]);
    end
    rx_frame(0, wave, waited, bc);
    checks++;
    if (waited != 0) begin
      errors++;
      $display("FAIL start_latency: got %0d idle cycles required 0", waited);
    end
    exp = exp_wave(sb.pop_front(), 0);
    checks++;
    if (wave !== exp) begin
      errors++;
      $display("FAIL frame_55: got %h required %h", wave, exp);
    end
    for (int j = 0; j < 11; j++) bits[j] = wave[j*4];
    checks++;
    if (bits !== 11'h4AA) begin
      errors++;
      $display("FAIL bits_55: got %b required %b", bits, 11'h4AA);
    end
    checks++;
    if (bc != 44) begin
      errors++;
      $display("FAIL busy_len_55: got %0d required 44", bc);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || txd[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_fall: got busy=%b txd=%b required 0/1", busy[0], txd[0]);
    end
  endtask

  task automatic test_parity;
    logic [63:0] wave, exp;
    int waited, bc;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(8'h07);
      write_word(k, 8'h07);
      rx_frame(k, wave, waited, bc);
      exp = exp_wave(sb.pop_front(), k);
      checks++;
      if (wave !== exp) begin
        errors++;
        $display("FAIL parity_frame[%0d]: got %h required %h", k, wave, exp);
      end
      checks++;
      if (wave[36] !== ((k == 1) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL parity_bit[%0d]: got %b required %b", k, wave[36], (k == 1) ? 1'b0 : 1'b1);
      end
      checks++;
      if (bc != ((k == 2) ? 40 : 44)) begin
        errors++;
        $display("FAIL parity_len[%0d]: got %0d required %0d", k, bc, (k == 2) ? 40 : 44);
      end
    end
  endtask

  task automatic test_two_stop;
    logic [63:0] wave, exp;
    int waited, bc;
    sb.push_back(8'hC3);
    write_word(3, 8'hC3);
    rx_frame(3, wave, waited, bc);
    exp = exp_wave(sb.pop_front(), 3);
    checks++;
    if (wave !== exp) begin
      errors++;
      $display("FAIL stop2_frame: got %h required %h", wave, exp);
    end
    checks++;
    if (bc != 48) begin
      errors++;
      $display("FAIL stop2_len: got %0d required 48", bc);
    end
    checks++;
    if (wave[47:40] !== 8'hFF) begin
      errors++;
      $display("FAIL stop2_tail: got %h required ff", wave[47:40]);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] wave, exp;
    int waited, bc, t;
    fork
      begin
        sb.push_back(8'hA1);
        write_word(0, 8'hA1);
        t = 0;
        while (busy[0] !== 1'b1 && t < 20) begin
          @(negedge clk);
          t++;
        end
        checks++;
        if (busy[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy_rise: got %b required 1", busy[0]);
        end
        for (int i = 1; i <= 5; i++) begin
          we[0] = 1'b1;
          wdata[0] = 8'(8'hB0 + i);
          if (i <= 4) sb.push_back(8'(8'hB0 + i));
          @(negedge clk);
        end
        we[0] = 1'b0;
        checks++;
        if (full[0] !== 1'b1 || count[0] !== 3'd4 || ovf[0] !== 1'b1) begin
          errors++;
          $display("FAIL overflow: got full=%b count=%0d ovf=%b required 1/4/1", full[0], count[0], ovf[0]);
        end
        we[0] = 1'b1;
        wdata[0] = 8'hEE;
        clr_ovf[0] = 1'b1;
        @(negedge clk);
        we[0] = 1'b0;
        clr_ovf[0] = 1'b0;
        checks++;
        if (ovf[0] !== 1'b1 || count[0] !== 3'd4) begin
          errors++;
          $display("FAIL ovf_set_wins: got ovf=%b count=%0d required 1/4", ovf[0], count[0]);
        end
        // Next pop lands on the edge that ends the first 44-cycle frame.
        repeat (37) @(negedge clk);
        we[0] = 1'b1;
        wdata[0] = 8'hC1;
        sb.push_back(8'hC1);
        @(negedge clk);
        we[0] = 1'b0;
        checks++;
        if (count[0] !== 3'd4 || full[0] !== 1'b1) begin
          errors++;
          $display("FAIL write_on_pop: got count=%0d full=%b required 4/1", count[0], full[0]);
        end
        checks++;
        if (ovf[0] !== 1'b1) begin
          errors++;
          $display("FAIL ovf_sticky: got %b required 1", ovf[0]);
        end
        clr_ovf[0] = 1'b1;
        @(negedge clk);
        clr_ovf[0] = 1'b0;
        checks++;
        if (ovf[0] !== 1'b0) begin
          errors++;
          $display("FAIL ovf_clear: got %b required 0", ovf[0]);
        end
      end
      begin
        for (int f = 0; f < 6; f++) begin
          rx_frame(0, wave, waited, bc);
          if (f > 0) begin
            checks++;
            if (waited != 0) begin
              errors++;
              $display("FAIL b2b_gap[%0d]: got %0d idle cycles required 0", f, waited);
            end
          end
          exp = (sb.size() > 0) ? exp_wave(sb.pop_front(), 0) : '1;
          checks++;
          if (wave !== exp) begin
            errors++;
            $display("FAIL b2b_frame[%0d]: got %h required %h", f, wave, exp);
          end
          checks++;
          if (bc != 44) begin
            errors++;
            $display("FAIL b2b_busy[%0d]: got %0d busy cycles required 44", f, bc);
          end
        end
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || empty[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_end: got busy=%b empty=%b required 0/1", busy[0], empty[0]);
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    logic bad;
    write_word(0, 8'h00);
    write_word(0, 8'h00);
    write_word(0, 8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (count[0] !== 3'd2 || txd[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got count=%0d txd=%b busy=%b required 2/0/1", count[0], txd[0], busy[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (txd[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_txd: got %b required 1", txd[0]);
    end
    checks++;
    if (count[0] !== 3'd0 || empty[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_flush: got count=%0d empty=%b busy=%b required 0/1/0", count[0], empty[0], busy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || count[0] !== 3'd0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: got activity=%b required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
